// File: rtl/ccff_stream_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : ccff_stream_loader_if
// Description : Bitstream word valid/ready channel from source to loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface ccff_stream_loader_if #(
    parameter int WORD_W = 32
);
    logic              word_valid;
    logic [WORD_W-1:0] word_data;
    logic              word_ready;

    modport master (
        output word_valid,
        output word_data,
        input  word_ready
    );

    modport slave (
        input  word_valid,
        input  word_data,
        output word_ready
    );
endinterface
`default_nettype wire

// File: rtl/ccff_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : ccff_stream_loader
// Description : Serializes bitstream words LSB-first onto a configuration
//               flip-flop chain; optional tail readback check enabled by
//               defining CCFF_VERIFY_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ccff_stream_loader #(
    parameter int CHAIN_LEN = 54,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 prog_clk,
    input  logic                 pReset_n,
    input  logic                 start,
    input  logic                 verify,
    ccff_stream_loader_if.slave  word_if,
    output logic                 ccff_head,
    output logic                 ccff_shift_en,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done,
    output logic                 verify_err
);

    localparam int                c_bl_w      = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  c_last_idx  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [c_bl_w-1:0] c_word_bits = c_bl_w'(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_SHIFT  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [WORD_W-1:0]   r_shreg;
    logic [c_bl_w-1:0]   r_bits_left;
    logic [CNT_W-1:0]    r_bits_sent;
    logic                r_head;
    logic                r_shift_en;
    logic                r_done;
    logic                r_verify;

    logic                w_word_ready;
    logic                w_pass_start;
    logic                w_load;
    logic                w_shift;
    logic                w_final;
    logic                w_word_end;
    logic [CNT_W-1:0]    w_sent_eff;
    logic [31:0]         w_remaining;
    logic [c_bl_w-1:0]   w_bits_init;

    assign w_final    = (r_bits_sent == c_last_idx);
    assign w_word_end = (r_bits_left == c_bl_w'(1));

    // A word loaded during the last shift of the previous word must count
    // that shift as already sent.
    assign w_sent_eff  = r_bits_sent + CNT_W'(r_state == S_SHIFT);
    assign w_remaining = 32'(CHAIN_LEN) - 32'(w_sent_eff);
    assign w_bits_init = (w_remaining < 32'(WORD_W)) ? c_bl_w'(w_remaining)
                                                     : c_word_bits;

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_word_ready = 1'b0;
        w_pass_start = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pass_start = 1'b1;
                    w_state_nxt  = S_FETCH;
                end
            end
            S_FETCH: begin
                w_word_ready = 1'b1;
                if (word_if.word_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_final) begin
                    w_state_nxt = S_FINISH;
                end else if (w_word_end) begin
                    w_word_ready = 1'b1;
                    if (word_if.word_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_FETCH;
                    end
                end else begin
                    w_shift = 1'b1;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_shreg     <= '0;
            r_bits_left <= '0;
            r_bits_sent <= '0;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_done      <= 1'b0;
            r_verify    <= 1'b0;
        end else begin
            if (w_pass_start) begin
                r_verify    <= verify;
                r_bits_sent <= '0;
            end else if (r_state == S_SHIFT) begin
                r_bits_sent <= r_bits_sent + CNT_W'(1);
            end

            // Leftover bits of a partial final word are simply never shifted.
            if (w_load) begin
                r_head      <= word_if.word_data[0];
                r_shreg     <= word_if.word_data >> 1;
                r_bits_left <= w_bits_init;
            end else if (w_shift) begin
                r_head      <= r_shreg[0];
                r_shreg     <= r_shreg >> 1;
                r_bits_left <= r_bits_left - c_bl_w'(1);
            end

            r_shift_en <= (w_state_nxt == S_SHIFT);
            r_done     <= (w_state_nxt == S_FINISH);
        end
    end

`ifdef CCFF_VERIFY_CHECK_EN
    logic r_verify_err;

    // The tail carries the previously loaded bit in step with the head.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_verify_err <= 1'b0;
        end else if (w_pass_start && verify) begin
            r_verify_err <= 1'b0;
        end else if (r_shift_en && r_verify && (ccff_tail != r_head)) begin
            r_verify_err <= 1'b1;
        end
    end

    assign verify_err = r_verify_err;
`else
    logic w_unused_verify;

    assign w_unused_verify = ccff_tail ^ r_verify;
    assign verify_err      = 1'b0;
`endif

    assign word_if.word_ready = w_word_ready;
    assign ccff_head          = r_head;
    assign ccff_shift_en      = r_shift_en;
    assign busy               = (r_state != S_IDLE);
    assign done               = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ccff_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccff_stream_loader
// Description : Directed self-checking bench for ccff_stream_loader with a
//               behavioural model of the configuration chain.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccff_stream_loader;

    localparam int N = 54;
    localparam int W = 32;

    logic prog_clk = 1'b0;
    logic pReset_n = 1'b0;
    logic start    = 1'b0;
    logic verify   = 1'b0;
    logic ccff_head, ccff_shift_en, ccff_tail, busy, done, verify_err;

    logic start1  = 1'b0;
    logic verify1 = 1'b0;
    logic tail1   = 1'b0;
    logic head1, shift_en1, busy1, done1, verr1;

    ccff_stream_loader_if #(.WORD_W(W)) sif ();
    ccff_stream_loader_if #(.WORD_W(W)) sif1 ();

    ccff_stream_loader #(.CHAIN_LEN(N), .WORD_W(W), .CNT_W(16)) dut (
        .prog_clk      (prog_clk),
        .pReset_n      (pReset_n),
        .start         (start),
        .verify        (verify),
        .word_if       (sif.slave),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .verify_err    (verify_err)
    );

    ccff_stream_loader #(.CHAIN_LEN(1), .WORD_W(W), .CNT_W(4)) dut1 (
        .prog_clk      (prog_clk),
        .pReset_n      (pReset_n),
        .start         (start1),
        .verify        (verify1),
        .word_if       (sif1.slave),
        .ccff_head     (head1),
        .ccff_shift_en (shift_en1),
        .ccff_tail     (tail1),
        .busy          (busy1),
        .done          (done1),
        .verify_err    (verr1)
    );

    always #5 prog_clk = ~prog_clk;

`ifdef CCFF_VERIFY_CHECK_EN
    localparam logic EXP_CHECK = 1'b1;
`else
    localparam logic EXP_CHECK = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Chain model: index 0 sits at the head, index N-1 drives the tail.
    logic [N-1:0] chain    = '0;
    logic         flip_req = 1'b0;

    always @(posedge prog_clk) begin
        if (flip_req)
            chain[N-1-17] <= ~chain[N-1-17];
        else if (ccff_shift_en)
            chain <= {chain[N-2:0], ccff_head};
    end

    assign ccff_tail = chain[N-1];

    int           cyc      = 0;
    int           sh_cnt   = 0;
    int           hs_cnt   = 0;
    int           done_cnt = 0;
    int           first_sh = -1;
    int           last_sh  = -1;
    int           hs_first = -1;
    int           done_cyc = -1;
    int           err_cyc  = -1;
    logic [N-1:0] cap      = '0;
    logic         mon_clr  = 1'b0;

    always @(negedge prog_clk) begin
        cyc <= cyc + 1;
        if (mon_clr) begin
            sh_cnt   <= 0;
            hs_cnt   <= 0;
            done_cnt <= 0;
            first_sh <= -1;
            last_sh  <= -1;
            hs_first <= -1;
            done_cyc <= -1;
            err_cyc  <= -1;
            cap      <= '0;
        end else begin
            if (ccff_shift_en) begin
                if (sh_cnt < N) cap[sh_cnt] <= ccff_head;
                if (sh_cnt == 0) first_sh <= cyc;
                last_sh <= cyc;
                sh_cnt  <= sh_cnt + 1;
            end
            if (sif.word_valid && sif.word_ready) begin
                if (hs_cnt == 0) hs_first <= cyc;
                hs_cnt <= hs_cnt + 1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (verify_err && busy && err_cyc < 0) err_cyc <= cyc;
        end
    end

    localparam logic [W-1:0] WORD0 = 32'hA5A5_F00F;
    localparam logic [W-1:0] WORD1 = 32'h003F_1234;

    logic [N-1:0] exp_bits;
    logic [N-1:0] exp_chain;
    logic [N-1:0] saved_chain;

    function automatic logic [N-1:0] reverse_bits(input logic [N-1:0] b);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[N-1-k] = b[k];
        return r;
    endfunction

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic clear_monitor();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    task automatic do_start(input logic v);
        start  = 1'b1;
        verify = v;
        tick();
        start  = 1'b0;
        verify = 1'b0;
    endtask

    // hold_low: cycles the source withholds valid after the loader first asks.
    task automatic send_word(input logic [W-1:0] w, input int hold_low);
        int n;
        n = 0;
        sif.word_data = w;
        if (hold_low > 0) begin
            sif.word_valid = 1'b0;
            while (!sif.word_ready && n < 500) begin tick(); n++; end
            repeat (hold_low) tick();
        end
        sif.word_valid = 1'b1;
        while (!sif.word_ready && n < 500) begin tick(); n++; end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL send_word_timeout: ready never seen, waited %0d cycles, required < 500", n);
        end
        tick();
        sif.word_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 500) begin tick(); n++; end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL done_timeout: done not seen after %0d cycles", n);
        end
        tick();
    endtask

    task automatic load_pass(input logic v, input int gap);
        clear_monitor();
        do_start(v);
        send_word(WORD0, 0);
        send_word(WORD1, gap);
        wait_done();
    endtask

    task automatic test_reset();
        sif.word_valid = 1'b0;
        sif.word_data  = '0;
        sif1.word_valid = 1'b0;
        sif1.word_data  = '0;
        repeat (3) tick();
        checks++; if ({ccff_head, ccff_shift_en, sif.word_ready, busy, done, verify_err} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs: got %b required 000000",
                {ccff_head, ccff_shift_en, sif.word_ready, busy, done, verify_err});
        end
        pReset_n = 1'b1;
        clear_monitor();
        sif.word_valid = 1'b1;
        sif.word_data  = WORD0;
        repeat (3) tick();
        sif.word_valid = 1'b0;
        checks++; if ({sif.word_ready, busy, ccff_shift_en} !== 3'b0) begin
            errors++; $display("FAIL idle_ignores_valid: ready/busy/shift_en got %b required 000",
                {sif.word_ready, busy, ccff_shift_en});
        end
        checks++; if (hs_cnt !== 0) begin
            errors++; $display("FAIL idle_handshakes: got %0d required 0", hs_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_monitor();
        do_start(1'b0);
        checks++; if (sif.word_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL start_to_ready: ready=%b busy=%b required 1 1", sif.word_ready, busy);
        end
        send_word(WORD0, 0);
        send_word(WORD1, 0);
        wait_done();
        checks++; if (sh_cnt !== N) begin
            errors++; $display("FAIL b2b_shift_count: got %0d required %0d", sh_cnt, N);
        end
        checks++; if (last_sh - first_sh + 1 !== N) begin
            errors++; $display("FAIL b2b_contiguous: span %0d required %0d", last_sh - first_sh + 1, N);
        end
        checks++; if (first_sh !== hs_first + 1) begin
            errors++; $display("FAIL b2b_first_bit_latency: first shift cycle %0d required %0d", first_sh, hs_first + 1);
        end
        checks++; if (cap !== exp_bits) begin
            errors++; $display("FAIL b2b_head_bits: got %h required %h", cap, exp_bits);
        end
        checks++; if (hs_cnt !== 2) begin
            errors++; $display("FAIL b2b_handshakes: got %0d required 2", hs_cnt);
        end
        checks++; if (done_cnt !== 1 || done_cyc !== last_sh + 1) begin
            errors++; $display("FAIL b2b_done: count %0d cycle %0d required 1 at %0d", done_cnt, done_cyc, last_sh + 1);
        end
        checks++; if (chain !== exp_chain) begin
            errors++; $display("FAIL b2b_chain: got %h required %h", chain, exp_chain);
        end
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle_after: busy got %b required 0", busy);
        end
        saved_chain = chain;
    endtask

    task automatic test_stall();
        chain = '0;
        load_pass(1'b0, 6);
        checks++; if (sh_cnt !== N) begin
            errors++; $display("FAIL stall_shift_count: got %0d required %0d", sh_cnt, N);
        end
        checks++; if ((last_sh - first_sh + 1) - sh_cnt !== 6) begin
            errors++; $display("FAIL stall_gap: got %0d idle cycles required 6", (last_sh - first_sh + 1) - sh_cnt);
        end
        checks++; if (chain !== saved_chain) begin
            errors++; $display("FAIL stall_chain: got %h required %h", chain, saved_chain);
        end
        checks++; if (done_cnt !== 1) begin
            errors++; $display("FAIL stall_done: got %0d required 1", done_cnt);
        end
    endtask

    task automatic test_verify();
        load_pass(1'b1, 0);
        checks++; if (verify_err !== 1'b0 || done_cnt !== 1) begin
            errors++; $display("FAIL verify_clean: err=%b done=%0d required 0 1", verify_err, done_cnt);
        end
        flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
        load_pass(1'b1, 0);
        checks++; if (verify_err !== EXP_CHECK) begin
            errors++; $display("FAIL verify_flip_err: got %b required %b", verify_err, EXP_CHECK);
        end
        if (EXP_CHECK) begin
            checks++; if (err_cyc !== first_sh + 18) begin
                errors++; $display("FAIL verify_flip_when: err rose cycle %0d required %0d", err_cyc, first_sh + 18);
            end
        end
        checks++; if (chain !== exp_chain) begin
            errors++; $display("FAIL verify_rewrite_chain: got %h required %h", chain, exp_chain);
        end
        load_pass(1'b0, 0);
        checks++; if (verify_err !== EXP_CHECK) begin
            errors++; $display("FAIL plain_keeps_err: got %b required %b", verify_err, EXP_CHECK);
        end
        do_start(1'b1);
        checks++; if (verify_err !== 1'b0) begin
            errors++; $display("FAIL verify_start_clears: got %b required 0", verify_err);
        end
        send_word(WORD0, 0);
        send_word(WORD1, 0);
        wait_done();
    endtask

    task automatic test_start_ignored();
        clear_monitor();
        do_start(1'b0);
        send_word(WORD0, 0);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        send_word(WORD1, 0);
        wait_done();
        repeat (5) tick();
        checks++; if (sh_cnt !== N || done_cnt !== 1 || hs_cnt !== 2) begin
            errors++; $display("FAIL start_ignored: shifts=%0d done=%0d hs=%0d required %0d 1 2", sh_cnt, done_cnt, hs_cnt, N);
        end
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL start_ignored_idle: busy got %b required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        clear_monitor();
        do_start(1'b0);
        send_word(WORD0, 0);
        while (sh_cnt < 30 && n < 200) begin tick(); n++; end
        checks++; if (sh_cnt !== 30) begin
            errors++; $display("FAIL reset_mid_position: shifts %0d required 30", sh_cnt);
        end
        pReset_n = 1'b0;
        #1;
        checks++; if ({ccff_head, ccff_shift_en, sif.word_ready, busy, done, verify_err} !== 6'b0) begin
            errors++; $display("FAIL reset_mid_outputs: got %b required 000000",
                {ccff_head, ccff_shift_en, sif.word_ready, busy, done, verify_err});
        end
        repeat (2) tick();
        checks++; if (done_cnt !== 0 || sh_cnt !== 30) begin
            errors++; $display("FAIL reset_mid_frozen: done=%0d shifts=%0d required 0 30", done_cnt, sh_cnt);
        end
        pReset_n = 1'b1;
        tick();
        load_pass(1'b0, 0);
        checks++; if (sh_cnt !== N || done_cnt !== 1) begin
            errors++; $display("FAIL reset_reload: shifts=%0d done=%0d required %0d 1", sh_cnt, done_cnt, N);
        end
        checks++; if (chain !== exp_chain) begin
            errors++; $display("FAIL reset_reload_chain: got %h required %h", chain, exp_chain);
        end
    endtask

    task automatic test_chain_len1();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checks++; if (sif1.word_ready !== 1'b1) begin
            errors++; $display("FAIL len1_ready: got %b required 1", sif1.word_ready);
        end
        sif1.word_valid = 1'b1;
        sif1.word_data  = 32'h0000_0001;
        tick();
        sif1.word_valid = 1'b0;
        checks++; if (shift_en1 !== 1'b1 || head1 !== 1'b1 || sif1.word_ready !== 1'b0) begin
            errors++; $display("FAIL len1_shift: shift_en=%b head=%b ready=%b required 1 1 0", shift_en1, head1, sif1.word_ready);
        end
        tick();
        checks++; if (shift_en1 !== 1'b0 || done1 !== 1'b1) begin
            errors++; $display("FAIL len1_done: shift_en=%b done=%b required 0 1", shift_en1, done1);
        end
        tick();
        checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL len1_idle: done=%b busy=%b required 0 0", done1, busy1);
        end
    endtask

    initial begin
        exp_bits  = {22'h3F_1234, 32'hA5A5_F00F};
        exp_chain = reverse_bits(exp_bits);
        test_reset();
        test_back_to_back();
        test_stall();
        test_verify();
        test_start_ignored();
        test_reset_mid();
        test_chain_len1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
